// File: rtl/seg_seq_pkg.sv
// Shared constants for the 7-segment sequence tracker: the cyclic digit
// sequence, command codes and active-high glyph patterns (bit 0 = a .. bit 6 = g).
package seg_seq_pkg;

  localparam int unsigned SEQ_LEN   = 9;
  localparam logic [3:0]  POS_CLEAR = 4'd9;
  localparam logic [3:0]  DIGIT_NONE = 4'd15;

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // SEQ = 3,5,2,8,4,0,2,1,8; indices outside 0..8 never match a digit.
  function automatic logic [3:0] seq_at(input logic [3:0] p);
    case (p)
      4'd0:    seq_at = 4'd3;
      4'd1:    seq_at = 4'd5;
      4'd2:    seq_at = 4'd2;
      4'd3:    seq_at = 4'd8;
      4'd4:    seq_at = 4'd4;
      4'd5:    seq_at = 4'd0;
      4'd6:    seq_at = 4'd2;
      4'd7:    seq_at = 4'd1;
      4'd8:    seq_at = 4'd8;
      default: seq_at = DIGIT_NONE;
    endcase
  endfunction

  function automatic logic [3:0] next_pos(input logic [3:0] p);
    next_pos = (p == 4'(SEQ_LEN - 1)) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [3:0] prev_pos(input logic [3:0] p);
    prev_pos = (p == 4'd0) ? 4'(SEQ_LEN - 1) : p - 4'd1;
  endfunction

endpackage

// File: rtl/seg_to_digit.sv
// Combinational 7-segment decoder: polarity correction, then glyph lookup.
// digit is 15 for blank or any pattern that is not a standard glyph.
module seg_to_digit
  import seg_seq_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [6:0] segmentos,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       legal
);

  logic [6:0] seg;

  assign seg = ACTIVE_LOW ? ~segmentos : segmentos;

  always_comb begin
    digit    = DIGIT_NONE;
    is_blank = 1'b0;
    legal    = 1'b1;
    case (seg)
      GLYPH_0:     digit = 4'd0;
      GLYPH_1:     digit = 4'd1;
      GLYPH_2:     digit = 4'd2;
      GLYPH_3:     digit = 4'd3;
      GLYPH_4:     digit = 4'd4;
      GLYPH_5:     digit = 4'd5;
      GLYPH_6:     digit = 4'd6;
      GLYPH_7:     digit = 4'd7;
      GLYPH_8:     digit = 4'd8;
      GLYPH_9:     digit = 4'd9;
      GLYPH_BLANK: is_blank = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_seq_tracker.sv
// Self-checker for the up/down digit-sequence display: tracks sequence position,
// recovers the command behind each displayed step and flags impossible steps.
//
// state        | meaning
// TRK_LOCKED   | pos is trusted; each sample is classified as hold/up/down/clear
// TRK_UNLOCKED | lost track; waiting for a digit that occurs once in the sequence
module seg_seq_tracker
  import seg_seq_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       seg_valid,
  input  logic [6:0] segmentos,
  output logic       cmd_valid,
  output logic [1:0] cmd,
  output logic [3:0] pos,
  output logic [3:0] digit,
  output logic       err,
  output logic       locked
);

  typedef enum logic {
    TRK_LOCKED,
    TRK_UNLOCKED
  } trk_state_t;

  trk_state_t state_q, state_d;
  logic [3:0] pos_d, digit_d;
  logic [1:0] cmd_d;
  logic       cmd_valid_d, err_d;

  logic [3:0] dec_digit;
  logic       dec_blank, dec_legal;

  seg_to_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
    .segmentos (segmentos),
    .digit     (dec_digit),
    .is_blank  (dec_blank),
    .legal     (dec_legal)
  );

  always_comb begin
    state_d     = state_q;
    pos_d       = pos;
    digit_d     = digit;
    cmd_d       = cmd;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;

    if (seg_valid) begin
      digit_d = dec_digit;
      case (state_q)
        TRK_LOCKED: begin
          if (pos == POS_CLEAR) begin
            if (dec_blank) begin
              cmd_d       = CMD_HOLD;
              cmd_valid_d = 1'b1;
            end else if (dec_digit == seq_at(4'd0)) begin
              cmd_d       = CMD_UP;
              cmd_valid_d = 1'b1;
              pos_d       = 4'd0;
            end else begin
              err_d   = 1'b1;
              state_d = TRK_UNLOCKED;
            end
          // dec_digit is 15 for blank/illegal, so those never match a sequence entry
          end else if (dec_digit == seq_at(pos)) begin
            cmd_d       = CMD_HOLD;
            cmd_valid_d = 1'b1;
          end else if (dec_digit == seq_at(next_pos(pos))) begin
            cmd_d       = CMD_UP;
            cmd_valid_d = 1'b1;
            pos_d       = next_pos(pos);
          end else if (dec_digit == seq_at(prev_pos(pos))) begin
            cmd_d       = CMD_DOWN;
            cmd_valid_d = 1'b1;
            pos_d       = prev_pos(pos);
          end else if (dec_blank) begin
            cmd_d       = CMD_CLEAR;
            cmd_valid_d = 1'b1;
            pos_d       = POS_CLEAR;
          end else begin
            err_d   = 1'b1;
            state_d = TRK_UNLOCKED;
          end
        end

        TRK_UNLOCKED: begin
          if (!dec_legal) begin
            err_d = 1'b1;
          end else if (dec_blank) begin
            pos_d   = POS_CLEAR;
            state_d = TRK_LOCKED;
          end else begin
            // 2 and 8 appear twice in the sequence and cannot fix the position
            case (dec_digit)
              4'd3: begin pos_d = 4'd0; state_d = TRK_LOCKED; end
              4'd5: begin pos_d = 4'd1; state_d = TRK_LOCKED; end
              4'd4: begin pos_d = 4'd4; state_d = TRK_LOCKED; end
              4'd0: begin pos_d = 4'd5; state_d = TRK_LOCKED; end
              4'd1: begin pos_d = 4'd7; state_d = TRK_LOCKED; end
              4'd2, 4'd8: ;
              default: err_d = 1'b1;
            endcase
          end
        end

        default: state_d = TRK_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= TRK_LOCKED;
      pos       <= 4'd0;
      digit     <= 4'd3;
      cmd       <= CMD_HOLD;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos       <= pos_d;
      digit     <= digit_d;
      cmd       <= cmd_d;
      cmd_valid <= cmd_valid_d;
      err       <= err_d;
    end
  end

  assign locked = (state_q == TRK_LOCKED);

endmodule

// File: tb/tb_seg_seq_tracker.sv
// Directed bench for seg_seq_tracker: a sequence-level reference model checked
// every cycle, plus literal expectations at the key steps.
module tb_seg_seq_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       seg_valid = 1'b0;
  logic [6:0] segmentos = 7'h7F;
  logic       cmd_valid, err, locked;
  logic [1:0] cmd;
  logic [3:0] pos, digit;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int SEQ   [9]  = '{3, 5, 2, 8, 4, 0, 2, 1, 8};
  int GLYPH [11] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F, 'h00};

  int m_pos = 0, m_digit = 3, m_cmd = 0;
  bit m_locked = 1'b1, m_cv = 1'b0, m_err = 1'b0;

  seg_seq_tracker #(.ACTIVE_LOW(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .seg_valid (seg_valid),
    .segmentos (segmentos),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .pos       (pos),
    .digit     (digit),
    .err       (err),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns 0..9 for a digit glyph, 10 for blank, -1 for anything else.
  function automatic int decode(input logic [6:0] s);
    int code = int'(~s & 7'h7F);
    for (int i = 0; i < 11; i++)
      if (GLYPH[i] == code) return i;
    return -1;
  endfunction

  function automatic int seq_count(input int d);
    int n = 0;
    for (int i = 0; i < 9; i++) if (SEQ[i] == d) n++;
    return n;
  endfunction

  function automatic int seq_index(input int d);
    for (int i = 0; i < 9; i++) if (SEQ[i] == d) return i;
    return -1;
  endfunction

  task automatic model_update(input bit rst, input bit v, input logic [6:0] s);
    int d, nx, pv;
    m_cv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_pos = 0; m_digit = 3; m_locked = 1'b1; m_cmd = 0;
    end else if (v) begin
      d = decode(s);
      m_digit = (d < 0 || d == 10) ? 15 : d;
      if (m_locked) begin
        if (m_pos == 9) begin
          if (d == 10) begin m_cmd = 0; m_cv = 1'b1; end
          else if (d == 3) begin m_cmd = 1; m_cv = 1'b1; m_pos = 0; end
          else begin m_err = 1'b1; m_locked = 1'b0; end
        end else begin
          nx = (m_pos + 1) % 9;
          pv = (m_pos + 8) % 9;
          if (d == SEQ[m_pos]) begin m_cmd = 0; m_cv = 1'b1; end
          else if (d == SEQ[nx]) begin m_cmd = 1; m_cv = 1'b1; m_pos = nx; end
          else if (d == SEQ[pv]) begin m_cmd = 2; m_cv = 1'b1; m_pos = pv; end
          else if (d == 10) begin m_cmd = 3; m_cv = 1'b1; m_pos = 9; end
          else begin m_err = 1'b1; m_locked = 1'b0; end
        end
      end else begin
        if (d == 10) begin m_pos = 9; m_locked = 1'b1; end
        else if (d >= 0 && seq_count(d) == 1) begin m_pos = seq_index(d); m_locked = 1'b1; end
        else if (d < 0 || seq_count(d) == 0) m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [6:0] s);
    @(negedge clock);
    reset = rst; seg_valid = v; segmentos = s;
    @(posedge clock);
    #1;
    model_update(rst, v, s);
  endtask

  task automatic smp(input logic [6:0] s);
    step(1'b0, 1'b1, s);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmd_valid", int'(cmd_valid), int'(m_cv));
      chk("err", int'(err), int'(m_err));
      chk("locked", int'(locked), int'(m_locked));
      chk("pos", int'(pos), m_pos);
      chk("digit", int'(digit), m_digit);
      chk("cmd", int'(cmd), m_cmd);
    end
  end

  initial begin
    logic [6:0] up_run [10] = '{7'h30, 7'h12, 7'h24, 7'h00, 7'h19, 7'h40, 7'h24, 7'h79, 7'h00, 7'h30};

    step(1'b1, 1'b0, 7'h7F);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 7'h7F);
    chk("reset_pos", int'(pos), 0);
    chk("reset_digit", int'(digit), 3);
    chk("reset_locked", int'(locked), 1);
    chk("reset_cv", int'(cmd_valid), 0);

    // full cycle of ups with wrap 8 -> 0
    foreach (up_run[i]) begin
      smp(up_run[i]);
      chk("run_cmd", int'(cmd), (i == 0) ? 0 : 1);
      chk("run_pos", int'(pos), (i == 0) ? 0 : i % 9);
    end

    // downward wrap 0 -> 8, then down, then hold
    step(1'b1, 1'b0, 7'h7F);
    smp(7'h00); chk("dn1_cmd", int'(cmd), 2); chk("dn1_pos", int'(pos), 8);
    smp(7'h79); chk("dn2_cmd", int'(cmd), 2); chk("dn2_pos", int'(pos), 7);
    smp(7'h79); chk("hold_cmd", int'(cmd), 0); chk("hold_pos", int'(pos), 7);

    // clear path
    smp(7'h7F); chk("clr_cmd", int'(cmd), 3); chk("clr_pos", int'(pos), 9); chk("clr_digit", int'(digit), 15);
    smp(7'h7F); chk("clr_hold", int'(cmd), 0);
    smp(7'h30); chk("clr_exit_cmd", int'(cmd), 1); chk("clr_exit_pos", int'(pos), 0);
    smp(7'h7F);
    smp(7'h12); chk("clr_bad_err", int'(err), 1); chk("clr_bad_lock", int'(locked), 0);

    // error at pos 0 then resync
    step(1'b1, 1'b0, 7'h7F);
    smp(7'h24); chk("bad_err", int'(err), 1); chk("bad_lock", int'(locked), 0); chk("bad_pos", int'(pos), 0);
    smp(7'h24); chk("amb2_cv", int'(cmd_valid), 0);
    smp(7'h00); chk("amb8_err", int'(err), 0);
    smp(7'h19); chk("sync_lock", int'(locked), 1); chk("sync_pos", int'(pos), 4); chk("sync_cv", int'(cmd_valid), 0);
    smp(7'h40); chk("post_sync_cmd", int'(cmd), 1); chk("post_sync_pos", int'(pos), 5);

    // illegal pattern at pos 3
    step(1'b1, 1'b0, 7'h7F);
    smp(7'h30); smp(7'h12); smp(7'h24); smp(7'h00);
    chk("pos3", int'(pos), 3);
    smp(7'h7E); chk("ill_err", int'(err), 1); chk("ill_digit", int'(digit), 15); chk("ill_lock", int'(locked), 0);
    smp(7'h7E); chk("ill_err_unl", int'(err), 1);

    // seg_valid low with toggling segments: no pulses
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 7'(i * 19));
      chk("idle_cv", int'(cmd_valid), 0);
    end

    // resync and walk to pos 6, then reset collides with a sample
    smp(7'h30); chk("resync3_pos", int'(pos), 0);
    smp(7'h12); smp(7'h24); smp(7'h00); smp(7'h19); smp(7'h40); smp(7'h24);
    chk("pos6", int'(pos), 6);
    step(1'b1, 1'b1, 7'h12);
    chk("rst_dom_pos", int'(pos), 0); chk("rst_dom_lock", int'(locked), 1); chk("rst_dom_cv", int'(cmd_valid), 0);
    step(1'b0, 1'b0, 7'h7F);

    @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
